forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, 32, operand data width.
REQ-002 SHALL have parameter DEPTH, 2, number of tracked post-EX stages (stage 1 = MEM, stage DEPTH = last writeback stage), legal 1..4.
REQ-003 SHALL have parameter NSRC, 2, number of EX source operands, legal 1..3.
REQ-004 SHALL have derived localparams: SELW = clog2(DEPTH+1), LATW = clog2(DEPTH), minimum 1.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port ex_valid, input, 1, valid instruction in EX.
REQ-008 SHALL have port ex_we, input, 1, EX instruction writes rd.
REQ-009 SHALL have port ex_rd, input, 5, EX destination register.
REQ-010 SHALL have port ex_lat, input, LATW, extra stages after MEM until result exists (0 = ALU, 1 = load).
REQ-011 SHALL have port ex_flush, input, 1, kill EX instruction (branch redirect).
REQ-012 SHALL have port ex_rs, input, NSRC*5, flattened source register indices, operand i at [5i+4:5i].
REQ-013 SHALL have port rf_data, input, NSRC*XLEN, register-file read values per operand.
REQ-014 SHALL have port stg_data, input, DEPTH*XLEN, result value held in post-EX stage k at slice k-1.
REQ-015 SHALL have port fwd_sel, output, NSRC*SELW, per operand: 0 = register file, k = stage k.
REQ-016 SHALL have port src_data, output, NSRC*XLEN, selected operand value.
REQ-017 SHALL have port stall, output, 1, EX must hold; ID/IF must freeze.
REQ-018 SHALL have port stall_cnt, output, 16, saturating count of stall cycles.

Function
REQ-019 SHALL keep DEPTH tracker entries, entry k = {valid, we, rd[4:0], rem[LATW-1:0]}, mirroring pipeline stage k.
REQ-020 On each non-reset edge, entries k=2..DEPTH SHALL load entry k-1, with rem = rem-1 saturating at 0.
REQ-021 On each non-reset edge, entry 1 SHALL load {ex_valid & ~ex_flush & ~stall, ex_we, ex_rd, min(ex_lat, DEPTH-1)}; stall inserts a bubble (valid=0).
REQ-022 Entry k SHALL be ready iff rem == 0.
REQ-023 Operand i SHALL match entry k iff valid & we & rd == rs_i & rs_i != 0.
REQ-024 fwd_sel_i SHALL be the lowest-numbered (youngest) matching k, else 0; older matches are ignored.
REQ-025 src_data_i SHALL equal stg_data slice (fwd_sel_i - 1) when fwd_sel_i != 0, else rf_data_i; fully combinational, zero latency.
REQ-026 stall SHALL be 1 iff ex_valid & ~ex_flush and any operand's youngest matching entry is not ready; combinational.
REQ-027 Forwarding from a not-ready entry SHALL still drive fwd_sel to that entry; data is don't-care while stall=1.
REQ-028 Register x0 SHALL never match, forward or stall.
REQ-029 ex_flush SHALL override stall (stall=0) and the flushed instruction SHALL not enter the tracker.
REQ-030 stall_cnt SHALL increment by 1 on each edge where stall=1, saturating at 16'hFFFF.
REQ-031 Consecutive stalls SHALL end without external action: bubbles advance producers until rem reaches 0.

Reset
REQ-032 When rst=1 at an edge, all entries SHALL become invalid with rem=0 and stall_cnt SHALL become 0.
REQ-033 After reset, fwd_sel SHALL be 0, src_data SHALL equal rf_data, and stall SHALL be 0 until a producer is tracked.
REQ-034 Reset asserted mid-stall SHALL clear the hazard on the following cycle, regardless of EX inputs held.

Verification
REQ-035 ALU back-to-back: cycle 0 EX writes x5 lat=0; cycle 1 EX reads x5 -> fwd_sel=1, src_data=stg_data[0], stall=0.
REQ-036 Load-use: cycle 0 EX load x6 lat=1; cycle 1 EX reads x6 -> stall=1 one cycle, stall_cnt=1; cycle 2 fwd_sel=2, stall=0.
REQ-037 Priority: stage1 and stage2 both write x7, EX reads x7 in both operands -> fwd_sel=1 for both.
REQ-038 x0: producer writes x0, EX reads x0 -> fwd_sel=0, src_data=rf_data, stall=0.
REQ-039 Flush and reset: load-use stall with ex_flush=1 -> stall=0, next entry1 invalid; rst during stall -> next cycle entries empty, stall_cnt=0.
REQ-040 Saturation: force 65540 stall cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/forward_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : forward_scoreboard
// Description : Tracks in-flight destination registers in the post-EX stages.
//               For each EX source operand it picks the youngest producer to
//               forward from, and stalls EX while that producer's result is
//               not yet available.
// Revision    : 1.0 - initial release
// ============================================================================
module forward_scoreboard #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int NSRC  = 2,
    localparam int SELW = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1),
    localparam int LATW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  logic                   ex_we,
    input  logic [4:0]             ex_rd,
    input  logic [LATW-1:0]        ex_lat,
    input  logic                   ex_flush,
    input  logic [NSRC*5-1:0]      ex_rs,
    input  logic [NSRC*XLEN-1:0]   rf_data,
    input  logic [DEPTH*XLEN-1:0]  stg_data,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic [NSRC*XLEN-1:0]   src_data,
    output logic                   stall,
    output logic [15:0]            stall_cnt
);

    // Largest meaningful latency: a result must exist by the last stage.
    localparam logic [LATW-1:0] C_MAX_LAT = LATW'(DEPTH - 1);

    // Tracker entries; index k holds pipeline stage k+1.
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_we;
    logic [4:0]       r_rd  [DEPTH];
    logic [LATW-1:0]  r_rem [DEPTH];
    logic [15:0]      r_stall_cnt;

    logic [LATW-1:0]  w_lat;
    logic [NSRC-1:0]  w_hz;
    logic             w_stall;

    assign w_lat = (ex_lat > C_MAX_LAT) ? C_MAX_LAT : ex_lat;

    // Advance the tracker with the pipeline; a stalled or flushed EX slot becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_we  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k]  <= '0;
                r_rem[k] <= '0;
            end
        end else begin
            r_vld[0] <= ex_valid & ~ex_flush & ~w_stall;
            r_we[0]  <= ex_we;
            r_rd[0]  <= ex_rd;
            r_rem[0] <= w_lat;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_we[k]  <= r_we[k-1];
                r_rd[k]  <= r_rd[k-1];
                r_rem[k] <= (r_rem[k-1] == '0) ? '0 : r_rem[k-1] - LATW'(1);
            end
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [4:0]      w_rs;
        logic [SELW-1:0] w_sel;
        logic [XLEN-1:0] w_data;
        logic            w_not_ready;

        assign w_rs = ex_rs[5*i +: 5];

        // Scan oldest to youngest so the youngest matching producer wins.
        always_comb begin
            w_sel       = '0;
            w_data      = rf_data[XLEN*i +: XLEN];
            w_not_ready = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (r_vld[k] && r_we[k] && (r_rd[k] == w_rs) && (w_rs != 5'd0)) begin
                    w_sel       = SELW'(k + 1);
                    w_data      = stg_data[XLEN*k +: XLEN];
                    w_not_ready = (r_rem[k] != '0);
                end
            end
        end

        assign fwd_sel[SELW*i +: SELW]  = w_sel;
        assign src_data[XLEN*i +: XLEN] = w_data;
        assign w_hz[i]                  = w_not_ready;
    end

    assign w_stall   = ex_valid & ~ex_flush & (|w_hz);
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_forward_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_scoreboard
// Description : Self-checking bench for forward_scoreboard (DEPTH=4, NSRC=2).
//               Expected outputs are queued when each EX instruction is driven
//               and compared when the combinational outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_scoreboard;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int NSRC  = 2;
    localparam int SELW  = 3;
    localparam int LATW  = 2;

    logic                  clk;
    logic                  rst;
    logic                  ex_valid;
    logic                  ex_we;
    logic [4:0]            ex_rd;
    logic [LATW-1:0]       ex_lat;
    logic                  ex_flush;
    logic [NSRC*5-1:0]     ex_rs;
    logic [NSRC*XLEN-1:0]  rf_data;
    logic [DEPTH*XLEN-1:0] stg_data;
    logic [NSRC*SELW-1:0]  fwd_sel;
    logic [NSRC*XLEN-1:0]  src_data;
    logic                  stall;
    logic [15:0]           stall_cnt;

    typedef struct {
        logic [SELW-1:0] sel0;
        logic [SELW-1:0] sel1;
        logic            stall;
        logic [15:0]     cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    forward_scoreboard #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .NSRC  (NSRC)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_we     (ex_we),
        .ex_rd     (ex_rd),
        .ex_lat    (ex_lat),
        .ex_flush  (ex_flush),
        .ex_rs     (ex_rs),
        .rf_data   (rf_data),
        .stg_data  (stg_data),
        .fwd_sel   (fwd_sel),
        .src_data  (src_data),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_src(input logic [SELW-1:0] sel, input int i);
        logic [31:0] v;
        if (sel == '0) v = rf_data[XLEN*i +: XLEN];
        else           v = stg_data[XLEN*(int'(sel) - 1) +: XLEN];
        return v;
    endfunction

    // Drive one EX cycle, queue its expectation, sample mid-cycle, then clock.
    task automatic step(input string tag,
                        input logic v, input logic we, input logic [4:0] rd,
                        input logic [LATW-1:0] lat, input logic fl,
                        input logic [4:0] rs0, input logic [4:0] rs1, input logic rst_v,
                        input logic [SELW-1:0] e_sel0, input logic [SELW-1:0] e_sel1,
                        input logic e_stall, input logic [15:0] e_cnt);
        exp_t e;
        exp_t o;
        ex_valid = v;
        ex_we    = we;
        ex_rd    = rd;
        ex_lat   = lat;
        ex_flush = fl;
        ex_rs    = {rs1, rs0};
        rst      = rst_v;
        e.sel0   = e_sel0;
        e.sel1   = e_sel1;
        e.stall  = e_stall;
        e.cnt    = e_cnt;
        exp_q.push_back(e);
        @(negedge clk);
        o = exp_q.pop_front();
        check_eq({tag, ".sel0"},  32'(fwd_sel[SELW-1:0]),    32'(o.sel0));
        check_eq({tag, ".sel1"},  32'(fwd_sel[2*SELW-1:SELW]), 32'(o.sel1));
        check_eq({tag, ".stall"}, 32'(stall),                32'(o.stall));
        check_eq({tag, ".cnt"},   32'(stall_cnt),            32'(o.cnt));
        if (!o.stall) begin
            check_eq({tag, ".src0"}, src_data[31:0],  exp_src(o.sel0, 0));
            check_eq({tag, ".src1"}, src_data[63:32], exp_src(o.sel1, 1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        ex_valid = 1'b0;
        ex_we    = 1'b0;
        ex_rd    = '0;
        ex_lat   = '0;
        ex_flush = 1'b0;
        ex_rs    = '0;
        rf_data  = {32'hB000_0001, 32'hB000_0000};
        stg_data = {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001};
        repeat (2) @(posedge clk);
        #1;

        //    tag           v  we rd     lat fl rs0    rs1    rst  sel0 sel1 st cnt
        step("reset",      0, 0, 5'd0,  0,  0, 5'd5,  5'd5,  0,   0,   0,   0, 0);
        // ALU back-to-back forwarding from stage 1
        step("alu_prod",   1, 1, 5'd5,  0,  0, 5'd0,  5'd0,  0,   0,   0,   0, 0);
        step("alu_fwd",    1, 0, 5'd0,  0,  0, 5'd5,  5'd3,  0,   1,   0,   0, 0);
        // Load-use: one stall cycle then forward from stage 2
        step("load",       1, 1, 5'd6,  1,  0, 5'd0,  5'd0,  0,   0,   0,   0, 0);
        step("lu_stall",   1, 1, 5'd9,  0,  0, 5'd6,  5'd5,  0,   1,   3,   1, 0);
        step("lu_fwd",     1, 1, 5'd9,  0,  0, 5'd6,  5'd5,  0,   2,   4,   0, 1);
        // Priority: youngest of two x7 producers wins in both operands
        step("pri_a",      1, 1, 5'd7,  0,  0, 5'd0,  5'd0,  0,   0,   0,   0, 1);
        step("pri_b",      1, 1, 5'd7,  0,  0, 5'd7,  5'd7,  0,   1,   1,   0, 1);
        step("pri_c",      1, 0, 5'd0,  0,  0, 5'd7,  5'd7,  0,   1,   1,   0, 1);
        // x0 never forwards or stalls, even behind a load to x0
        step("x0_prod",    1, 1, 5'd0,  1,  0, 5'd0,  5'd0,  0,   0,   0,   0, 1);
        step("x0_read",    1, 0, 5'd0,  0,  0, 5'd0,  5'd0,  0,   0,   0,   0, 1);
        // Flush overrides a load-use stall and the flushed write is dropped
        step("fl_load",    1, 1, 5'd6,  1,  0, 5'd0,  5'd0,  0,   0,   0,   0, 1);
        step("flush",      1, 1, 5'd8,  0,  1, 5'd6,  5'd0,  0,   1,   0,   0, 1);
        step("post_flush", 1, 0, 5'd0,  0,  0, 5'd8,  5'd6,  0,   0,   2,   0, 1);
        // Reset during a stall clears the hazard and the counter
        step("rst_load",   1, 1, 5'd11, 1,  0, 5'd0,  5'd0,  0,   0,   0,   0, 1);
        step("rst_stall",  1, 0, 5'd0,  0,  0, 5'd11, 5'd0,  1,   1,   0,   1, 1);
        step("rst_clear",  1, 0, 5'd0,  0,  0, 5'd11, 5'd0,  0,   0,   0,   0, 0);
        // Longest latency: three stall cycles resolve on their own
        step("lat3_prod",  1, 1, 5'd12, 3,  0, 5'd0,  5'd0,  0,   0,   0,   0, 0);
        step("lat3_s1",    1, 0, 5'd0,  0,  0, 5'd12, 5'd12, 0,   1,   1,   1, 0);
        step("lat3_s2",    1, 0, 5'd0,  0,  0, 5'd12, 5'd12, 0,   2,   2,   1, 1);
        step("lat3_s3",    1, 0, 5'd0,  0,  0, 5'd12, 5'd12, 0,   3,   3,   1, 2);
        step("lat3_go",    1, 0, 5'd0,  0,  0, 5'd12, 5'd12, 0,   4,   4,   0, 3);

        // Saturation: a self-dependent lat=3 instruction stalls 3 of every 4 cycles.
        // Stall count entering cycle c is 3 + c - ceil(c/4).
        for (int c = 0; c <= 88000; c++) begin
            if (c == 8)
                step("sat_c8",    1, 1, 5'd13, 3, 0, 5'd13, 5'd13, 0, 4, 4, 0, 16'd9);
            else if (c == 9)
                step("sat_c9",    1, 1, 5'd13, 3, 0, 5'd13, 5'd13, 0, 1, 1, 1, 16'd9);
            else if (c == 87375)
                step("sat_pre",   1, 1, 5'd13, 3, 0, 5'd13, 5'd13, 0, 3, 3, 1, 16'hFFFE);
            else if (c == 87376)
                step("sat_hit",   1, 1, 5'd13, 3, 0, 5'd13, 5'd13, 0, 4, 4, 0, 16'hFFFF);
            else if (c == 87999)
                step("sat_hold",  1, 1, 5'd13, 3, 0, 5'd13, 5'd13, 0, 3, 3, 1, 16'hFFFF);
            else if (c == 88000)
                step("sat_final", 1, 1, 5'd13, 3, 0, 5'd13, 5'd13, 0, 4, 4, 0, 16'hFFFF);
            else begin
                ex_valid = 1'b1;
                ex_we    = 1'b1;
                ex_rd    = 5'd13;
                ex_lat   = 2'd3;
                ex_flush = 1'b0;
                ex_rs    = {5'd13, 5'd13};
                rst      = 1'b0;
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
